mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port, asynchronous-read, synchronous-write word memory between the instruction-fetch port and the load/store data port of the MIPS core. Each requester uses a req/ack handshake. The arbiter picks one winner per access, drives the memory address, write data and write enable for one cycle, then returns registered read data with a one-cycle ack pulse. It sits between the core's fetch and memory stages and the `memory` instance.

## Interface
- `ADDR_SIZE`, default 5: word-address width; must match the memory instance.
- `WORD_SIZE`, default 32: data width.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req`  in  1  fetch request; held high until `i_ack`.
- `i_addr`  in  ADDR_SIZE  fetch address; stable while `i_req` is high.
- `i_ack`  out  1  one-cycle pulse; fetch complete.
- `i_rdata`  out  WORD_SIZE  fetch data; valid while `i_ack` is high, held afterwards.
- `d_req`  in  1  data request; held high until `d_ack`.
- `d_addr`  in  ADDR_SIZE  data address; stable while `d_req` is high.
- `d_wdata`  in  WORD_SIZE  store data; stable while `d_req` is high.
- `d_wen`  in  1  1 = store, 0 = load; stable while `d_req` is high.
- `d_ack`  out  1  one-cycle pulse; load or store complete.
- `d_rdata`  out  WORD_SIZE  load data, or the pre-store word for a store; valid while `d_ack` is high.
- `mem_addr`  out  ADDR_SIZE  to memory `addr`.
- `mem_wdata`  out  WORD_SIZE  to memory `wdata`; always equals `d_wdata`.
- `mem_wen`  out  1  to memory `wen`.
- `mem_rdata`  in  WORD_SIZE  from memory `rdata` (combinational read).

## Operation
- FSM has three states: IDLE, BUSY, ACK. A registered `sel` selects I or D.
- **IDLE**
  - If neither port requests, stay in IDLE.
  - Otherwise choose a winner (see arbitration below), load `sel`, and go to BUSY.
- **BUSY** (exactly one cycle)
  - `mem_addr` = address of the `sel` port.
  - `mem_wen` = `sel==D && d_wen && !rst`.
  - At the clock edge, capture `mem_rdata` into `sel`'s rdata register, set `sel`'s ack, and go to ACK.
- **ACK**
  - The acked port's ack is high for this cycle only.
  - The acked port's `req` is ignored this cycle, because it is still asserted.
  - If the other port requests, grant it: load `sel` and go to BUSY.
  - Otherwise go to IDLE.
- **Arbitration:** round-robin or fixed priority; see Configuration.
- **Outside BUSY:** `mem_wen` = 0 and `mem_addr` = address of the `sel` port.
- **Store read-back:** `d_rdata` on a store is the old word. Memory read is combinational and the write commits at the end of BUSY.
- **Not allowed:** dropping `req` before ack, or changing address/data while `req` is high. Behaviour in these cases is undefined; the verifier flags them as assertion errors.

## Timing
- **Reset:**
  - state = IDLE, `sel` = D.
  - Round-robin pointer `last` = I, so D wins the first contention.
  - `i_ack` = `d_ack` = 0, `i_rdata` = `d_rdata` = 0, `mem_wen` = 0.
  - `mem_addr` = `d_addr`; `mem_wdata` = `d_wdata`.
- **Latency:** `req` sampled high in IDLE at edge N gives BUSY in cycle N+1 and ack in cycle N+2.
- **Throughput:**
  - Alternating ports: one access every 2 cycles (ACK → BUSY).
  - Same port back-to-back: one access every 3 cycles (ACK → IDLE → BUSY).
- **Reset mid-operation:**
  - `rst` high in BUSY suppresses `mem_wen` in that cycle, so no write occurs.
  - The next state is IDLE and the pending ack is discarded.
  - `rst` high in ACK clears ack at the following edge. The current-cycle ack pulse has already been seen by the requester.

## Configuration
- **`MEM_ARB_RR_EN` defined:** round-robin.
  - On contention, grant the port not granted last.
  - `last` updates on every entry to BUSY.
  - No port waits more than one access.
- **`MEM_ARB_RR_EN` undefined:** fixed priority.
  - D always wins contention; `last` is not implemented.
  - A continuously requesting D starves I. This is accepted.

## Test plan
Memory model is preloaded with word i = i.

1. **Reset values:** hold `rst` for 2 cycles with both reqs high → all acks 0, rdata 0, `mem_wen` 0 throughout; D granted first after release.
2. **Single fetch:** `i_req` with `i_addr`=3 from IDLE → `mem_addr`=3 in cycle N+1; `i_ack`=1 and `i_rdata`=3 in N+2 only; `d_ack` stays 0.
3. **Store then load:** store 0xDEADBEEF to 7 → `mem_wen`=1 for exactly one cycle, `d_rdata`=7 on ack. Then load 7 → `d_rdata`=0xDEADBEEF.
4. **Contention:** `i_addr`=1 and `d_addr`=2 requested together and held after each ack.
   - With `MEM_ARB_RR_EN`: acks alternate D, I, D, I, each 2 cycles apart.
   - Without it: only `d_ack` pulses, every 3 cycles.
5. **Reset during write:** store 0x55 to 4, with `rst` pulsed during BUSY → no `mem_wen`, no `d_ack`. A later load of 4 returns 4.
6. **Same-port back-to-back:** `i_req` held high over addresses 5 then 6 (address changed after ack) → acks 3 cycles apart with `i_rdata` 5 then 6.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port word memory between the instruction-fetch port (I)
//   and the load/store data port (D) of the core. The memory reads
//   asynchronously and writes synchronously.
//
//   Each access takes three steps:
//     1. A winner is picked.
//     2. The memory is driven for one BUSY cycle.
//     3. The read word is returned in a register, with a one-cycle ack pulse.
//
//   Build option:
//     MEM_ARB_RR_EN  defined   : round-robin on contention (grant the port not
//                                granted last).
//                    undefined : fixed priority, D always wins contention.
//
//   Ports:
//     clk, rst            clock; synchronous active-high reset
//     i_req/i_addr        fetch request and word address (held until i_ack)
//     i_ack/i_rdata       fetch done pulse and fetched word (held afterwards)
//     d_req/d_addr        data request and word address (held until d_ack)
//     d_wdata/d_wen       store data and store (1) / load (0) select
//     d_ack/d_rdata       data done pulse; load data, or the old word on a store
//     mem_addr/mem_wdata  memory address and write data
//     mem_wen             memory write enable, high only in a BUSY store cycle
//     mem_rdata           memory combinational read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int unsigned ADDR_SIZE = 5,
   parameter int unsigned WORD_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   // fetch port
   input  logic                 i_req,
   input  logic [ADDR_SIZE-1:0] i_addr,
   output logic                 i_ack,
   output logic [WORD_SIZE-1:0] i_rdata,
   // load/store port
   input  logic                 d_req,
   input  logic [ADDR_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   input  logic                 d_wen,
   output logic                 d_ack,
   output logic [WORD_SIZE-1:0] d_rdata,
   // memory side
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   output logic                 mem_wen,
   input  logic [WORD_SIZE-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   localparam logic SEL_I = 1'b0;
   localparam logic SEL_D = 1'b1;

   state_e               state_q, state_d;
   logic                 sel_q, sel_d;
   logic                 i_ack_q, i_ack_d;
   logic                 d_ack_q, d_ack_d;
   logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
   logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
   logic                 grant_c;    // winner when arbitrating out of IDLE
   logic                 handoff_c;  // move straight from ACK to the other port
`ifdef MEM_ARB_RR_EN
   logic                 last_q, last_d;
`endif

   // Fresh arbitration out of IDLE.
   always_comb begin
      grant_c = SEL_D;
      if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
         grant_c = ~last_q;
`else
         grant_c = SEL_D;
`endif
      end else if (i_req) begin
         grant_c = SEL_I;
      end
   end

   // Decide whether ACK hands over to the other port.
   // The acked port's req is still high in ACK, so only the other port counts.
`ifdef MEM_ARB_RR_EN
   assign handoff_c = (sel_q == SEL_D) ? i_req : d_req;
`else
   // After serving D, return to IDLE so that a D still requesting wins again.
   assign handoff_c = (sel_q == SEL_I) && d_req;
`endif

   // Next-state, grant and read-capture logic.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      i_ack_d   = 1'b0;
      d_ack_d   = 1'b0;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
      last_d    = last_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_req || d_req) begin
               sel_d   = grant_c;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // A store captures the old word: the write commits on this same edge.
            if (sel_q == SEL_D) begin
               d_rdata_d = mem_rdata;
               d_ack_d   = 1'b1;
            end else begin
               i_rdata_d = mem_rdata;
               i_ack_d   = 1'b1;
            end
            state_d = ST_ACK;
         end
         ST_ACK: begin
            if (handoff_c) begin
               sel_d   = ~sel_q;
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef MEM_ARB_RR_EN
      if (state_d == ST_BUSY) begin
         last_d = sel_d;
      end
`endif
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sel_q     <= SEL_D;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
         last_q    <= SEL_I;
`endif
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         i_ack_q   <= i_ack_d;
         d_ack_q   <= d_ack_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
         last_q    <= last_d;
`endif
      end
   end

   // Memory drive: the address follows sel in every state.
   // Reset in BUSY blocks the write.
   assign mem_addr  = (sel_q == SEL_D) ? d_addr : i_addr;
   assign mem_wdata = d_wdata;
   assign mem_wen   = (state_q == ST_BUSY) && (sel_q == SEL_D) && d_wen && !rst;

   assign i_ack   = i_ack_q;
   assign d_ack   = d_ack_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural word memory (word i = i).
//   A cycle table covers single fetch, store/load, reset during a write, and
//   same-port back-to-back accesses. Hand sequences cover reset with both
//   ports requesting, and sustained contention.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam logic [DW-1:0] DB = 32'hDEADBEEF;
`ifdef MEM_ARB_RR_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req, d_req, d_wen;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          i_ack, d_ack, mem_wen;
   logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   logic [DW-1:0] mem [32];

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wen     (d_wen),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wen   (mem_wen),
      .mem_rdata (mem_rdata)
   );

   // Behavioural memory: combinational read, write on the rising edge.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_wen) mem[mem_addr] <= mem_wdata;
   end

   typedef struct {
      logic          rst;
      logic          ireq;
      logic [AW-1:0] iaddr;
      logic          dreq;
      logic [AW-1:0] daddr;
      logic [DW-1:0] wdata;
      logic          wen;
      bit            chk;
      logic          eiack;
      logic          edack;
      logic [DW-1:0] eir;
      logic [DW-1:0] edr;
      logic          emwen;
      logic [AW-1:0] emaddr;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic add(input logic r, input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic [AW-1:0] da, input logic [DW-1:0] wd,
                      input logic we, input bit c, input logic eia, input logic eda,
                      input logic [DW-1:0] eir, input logic [DW-1:0] edr,
                      input logic emw, input logic [AW-1:0] ema);
      vec_t v;
      v.rst = r; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.daddr = da;
      v.wdata = wd; v.wen = we; v.chk = c; v.eiack = eia; v.edack = eda;
      v.eir = eir; v.edr = edr; v.emwen = emw; v.emaddr = ema;
      vq.push_back(v);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit got_d, got_i, exp_d, exp_i;

      for (int k = 0; k < 32; k++) mem[k] = DW'(k);

      // ---- Reset with both ports requesting; D must be granted first ----
      rst = 1'b1; i_req = 1'b1; i_addr = 5'd1; d_req = 1'b1; d_addr = 5'd2;
      d_wen = 1'b0; d_wdata = '0;
      next_cycle();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check($sformatf("rst%0d i_ack", c), DW'(i_ack), 0);
         check($sformatf("rst%0d d_ack", c), DW'(d_ack), 0);
         check($sformatf("rst%0d i_rdata", c), i_rdata, 0);
         check($sformatf("rst%0d d_rdata", c), d_rdata, 0);
         check($sformatf("rst%0d mem_wen", c), DW'(mem_wen), 0);
         check($sformatf("rst%0d mem_addr", c), DW'(mem_addr), 2);
         next_cycle();
      end
      rst = 1'b0;
      got_d = 1'b0; got_i = 1'b0;
      for (int c = 0; c < 20 && !(got_d && got_i); c++) begin
         @(negedge clk);
         check("t1 mem_wen", DW'(mem_wen), 0);
         if (d_ack) begin
            check("t1 d_ack latency", DW'(c), 2);
            check("t1 d_rdata", d_rdata, 2);
            check("t1 d granted before i", DW'(got_i), 0);
            got_d = 1'b1;
         end
         if (i_ack) begin
            check("t1 i_rdata", i_rdata, 1);
            check("t1 i granted after d", DW'(got_d), 1);
            got_i = 1'b1;
         end
         next_cycle();
         if (got_d) d_req = 1'b0;
         if (got_i) i_req = 1'b0;
      end
      check("t1 both ports acked", DW'({got_d, got_i}), 3);
      i_req = 1'b0; d_req = 1'b0;
      next_cycle();

      // ---- Cycle table ----
      //  rst ireq ia dreq da wdata wen chk | iack dack i_rdata d_rdata mwen maddr
      add(1,0,0,0,0,0,0,   0, 0,0,0,0,0,0);
      // single fetch from 3
      add(0,1,3,0,0,0,0,   1, 0,0,0,0,0,0);
      add(0,1,3,0,0,0,0,   1, 0,0,0,0,0,3);
      add(0,1,3,0,0,0,0,   1, 1,0,3,0,0,3);
      add(0,0,3,0,0,0,0,   1, 0,0,3,0,0,3);
      // store DEADBEEF to 7, old word returned
      add(0,0,3,1,7,DB,1,  1, 0,0,3,0,0,3);
      add(0,0,3,1,7,DB,1,  1, 0,0,3,0,1,7);
      add(0,0,3,1,7,DB,1,  1, 0,1,3,7,0,7);
      add(0,0,3,0,7,0,0,   1, 0,0,3,7,0,7);
      // load 7
      add(0,0,3,1,7,0,0,   1, 0,0,3,7,0,7);
      add(0,0,3,1,7,0,0,   1, 0,0,3,7,0,7);
      add(0,0,3,1,7,0,0,   1, 0,1,3,DB,0,7);
      add(0,0,3,0,7,0,0,   1, 0,0,3,DB,0,7);
      // store 0x55 to 4, reset lands in BUSY
      add(0,0,3,1,4,32'h55,1, 1, 0,0,3,DB,0,4);
      add(1,0,3,1,4,32'h55,1, 1, 0,0,3,DB,0,4);
      add(0,0,3,0,4,32'h55,0, 1, 0,0,0,0,0,4);
      add(0,0,3,0,4,0,0,   1, 0,0,0,0,0,4);
      // load 4 still returns 4
      add(0,0,3,1,4,0,0,   1, 0,0,0,0,0,4);
      add(0,0,3,1,4,0,0,   1, 0,0,0,0,0,4);
      add(0,0,3,1,4,0,0,   1, 0,1,0,4,0,4);
      add(0,0,3,0,4,0,0,   1, 0,0,0,4,0,4);
      // same-port back-to-back fetch: 5 then 6, acks 3 cycles apart
      add(0,1,5,0,4,0,0,   1, 0,0,0,4,0,4);
      add(0,1,5,0,4,0,0,   1, 0,0,0,4,0,5);
      add(0,1,5,0,4,0,0,   1, 1,0,5,4,0,5);
      add(0,1,6,0,4,0,0,   1, 0,0,5,4,0,6);
      add(0,1,6,0,4,0,0,   1, 0,0,5,4,0,6);
      add(0,1,6,0,4,0,0,   1, 1,0,6,4,0,6);
      add(0,0,6,0,4,0,0,   1, 0,0,6,4,0,6);

      for (int k = 0; k < vq.size(); k++) begin
         rst = vq[k].rst; i_req = vq[k].ireq; i_addr = vq[k].iaddr;
         d_req = vq[k].dreq; d_addr = vq[k].daddr; d_wdata = vq[k].wdata;
         d_wen = vq[k].wen;
         @(negedge clk);
         if (vq[k].chk) begin
            check($sformatf("row%0d i_ack", k), DW'(i_ack), DW'(vq[k].eiack));
            check($sformatf("row%0d d_ack", k), DW'(d_ack), DW'(vq[k].edack));
            check($sformatf("row%0d i_rdata", k), i_rdata, vq[k].eir);
            check($sformatf("row%0d d_rdata", k), d_rdata, vq[k].edr);
            check($sformatf("row%0d mem_wen", k), DW'(mem_wen), DW'(vq[k].emwen));
            check($sformatf("row%0d mem_addr", k), DW'(mem_addr), DW'(vq[k].emaddr));
         end
         next_cycle();
      end

      // ---- Sustained contention: I at 1, D at 2, both held ----
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
      next_cycle();
      rst = 1'b0;
      i_req = 1'b1; i_addr = 5'd1; d_req = 1'b1; d_addr = 5'd2;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (RR_MODE) begin
            exp_d = (k >= 2) && ((k - 2) % 4 == 0);
            exp_i = (k >= 4) && ((k - 4) % 4 == 0);
         end else begin
            exp_d = (k >= 2) && ((k - 2) % 3 == 0);
            exp_i = 1'b0;
         end
         check($sformatf("cont%0d d_ack", k), DW'(d_ack), DW'(exp_d));
         check($sformatf("cont%0d i_ack", k), DW'(i_ack), DW'(exp_i));
         if (exp_d) check($sformatf("cont%0d d_rdata", k), d_rdata, 2);
         if (exp_i) check($sformatf("cont%0d i_rdata", k), i_rdata, 1);
         next_cycle();
      end
      i_req = 1'b0; d_req = 1'b0;
      next_cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
